dsu_uart_txsched: RTL and testbench
===================================

# dsu_uart_txsched

Transmit scheduler that shares the single DSU uartlite byte transmitter between two requesters: port 0 is the DSU debug responder and port 1 is the CPU console path. It arbitrates round-robin at packet granularity and holds the grant until a byte marked `last`. It sequences each byte into the transmitter with a one-cycle start pulse and tracks the transmitter busy flag through to completion. It sits between the requesters and the `dsu_Tx` start/data/busy interface, and is clocked and reset with the rest of the DSU.

## Interface
Parameters:
- START_TO, 4: cycles to wait after `tx_start` for `tx_busy` to rise before the byte is declared lost.
- HOLD_TO, 1024: idle cycles a locked owner may leave `reqN_valid` low before its lock is revoked.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 (debug) has a byte.
- req0_data  in  8  requester 0 byte.
- req0_last  in  1  this byte ends requester 0's packet.
- req0_ready  out  1  requester 0 byte accepted this cycle when valid is also high.
- req1_valid, req1_data[7:0], req1_last, req1_ready: same as port 0, for requester 1 (CPU console).
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  8  byte presented to the transmitter.
- tx_busy  in  1  transmitter busy flag.
- grant  out  2  one-hot current owner; 00 when unowned.
- sched_busy  out  1  high in any state other than IDLE.
- start_err  out  1  one-cycle pulse when START_TO expires.
- lock_abort  out  1  one-cycle pulse when HOLD_TO revokes a lock.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD.
- **IDLE, arbitration**
  - Grant goes to the only valid requester.
  - If both are valid, grant goes to the requester not served last; `last_served` resets to 1, so port 0 wins the first tie.
  - `reqN_ready` is combinational: 1 in IDLE for the chosen requester while its valid is high.
- **Accept**
  - On `valid && ready`, latch data into `tx_data`, set `grant`, record `last`, update `last_served`.
  - Go to START.
- **START**
  - `tx_start` = 1 for exactly one cycle.
  - Go to WAIT_BUSY and clear the timeout counter.
- **WAIT_BUSY**
  - `tx_busy` = 1 → go to WAIT_DONE.
  - Counter reaches START_TO → pulse `start_err`, then leave as if the byte completed (next bullet).
- **WAIT_DONE**
  - `tx_busy` = 0 → byte complete.
  - If the recorded `last` = 1: clear `grant`, go to IDLE.
  - Otherwise go to HOLD.
- **HOLD**
  - Only the owner sees `ready` = 1; the other requester's `ready` stays 0.
  - Owner acceptance → START.
  - Owner valid low for HOLD_TO consecutive cycles → pulse `lock_abort`, clear `grant`, go to IDLE.
  - The hold counter resets whenever the owner's valid is high.
- `tx_data` is stable from the accept edge until the next accept.
- Counters saturate and never wrap.
- Simultaneous events:
  - Both requesters valid in HOLD: only the owner is served.
  - A requester presenting `last` = 1 on the first byte of a packet sends a single-byte packet with no HOLD.
- Reset mid-operation:
  - All state returns to reset values immediately, with no completion of the pending byte.
  - The transmitter shares `rst`.
- Reset values:
  - `req0_ready` = `req1_ready` = 0 while `rst` is low (the combinational ready is gated by reset).
  - `tx_start` = 0, `tx_data` = 8'h00, `grant` = 2'b00, `sched_busy` = 0, `start_err` = 0, `lock_abort` = 0.
  - State = IDLE, `last_served` = 1, both counters = 0.

## Timing
- Accept at edge T:
  - `tx_start` = 1 during cycle T+1.
  - Earliest WAIT_DONE entry is T+3, since `tx_busy` rises one cycle after start.
- `tx_busy` sampled low at edge D → next accept possible in cycle D+1, from IDLE or HOLD.
- Minimum overhead is 3 cycles per byte beyond the transmitter busy time.
- `start_err` is asserted START_TO cycles after the `tx_start` cycle.
- `lock_abort` is asserted HOLD_TO cycles after the owner's valid drops in HOLD.
- `grant` and `sched_busy` are registered.
- `reqN_ready` is combinational from state, owner and valids, with no path from `reqN_data`.

## Test plan
- **Single byte:** req0_valid=1, data=8'h55, last=1, model busy 10 cycles → `req0_ready` for one cycle, `tx_start` one cycle later with `tx_data`=8'h55, `grant` returns to 00 after busy falls, exactly one start.
- **Tie round-robin:** both requesters valid with single-byte packets 8'hA0 and 8'hB0 held continuously → transmit order A0, B0, A0, B0, starting with port 0 after reset.
- **Lock:** req1 sends a 3-byte packet 8'h01, 8'h02, 8'h03 (`last` on 03) while req0 is valid throughout → req1 bytes back-to-back with `req0_ready` = 0, then req0 is served.
- **Lock abort:** req1 sends one byte with last=0, then drops valid; HOLD_TO=8 → `lock_abort` pulse 8 cycles into HOLD, `grant` = 00, pending req0 is then served.
- **Start timeout:** `tx_busy` tied 0, START_TO=4 → `start_err` pulse 4 cycles after `tx_start`, scheduler returns to IDLE/HOLD and continues.
- **Reset mid-byte:** assert `rst` low during WAIT_DONE → all outputs at reset values while low; after release, the next valid request proceeds normally.

Source files
------------

// File: rtl/dsu_uart_txsched.sv
// Shares the DSU uartlite byte transmitter between the debug responder (port 0)
// and the CPU console (port 1), round-robin per packet, one start pulse per byte.
module dsu_uart_txsched #(
  parameter int START_TO = 4,
  parameter int HOLD_TO  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       sched_busy,
  output logic       start_err,
  output logic       lock_abort
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;

  localparam int CNT_MAX = (START_TO > HOLD_TO) ? START_TO : HOLD_TO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_TO - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic             served_q, served_d;
  logic [7:0]       data_q, data_d;
  logic             start_q, start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             busy_q, busy_d;

  logic pick1, rdy0, rdy1, accept, serr, done;

  // Port 1 wins a tie only when port 0 was served last.
  always_comb begin
    pick1 = req1_valid && (!req0_valid || !served_q);
    rdy0  = 1'b0;
    rdy1  = 1'b0;
    if (state_q == S_IDLE) begin
      rdy0 = req0_valid && !pick1;
      rdy1 = pick1;
    end else if (state_q == S_HOLD) begin
      rdy0 = grant_q[0] && req0_valid;
      rdy1 = grant_q[1] && req1_valid;
    end
    accept = rdy0 || rdy1;
  end

  assign req0_ready = rst && rdy0;
  assign req1_ready = rst && rdy1;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    served_d = served_q;
    data_d   = data_q;
    start_d  = 1'b0;
    cnt_d    = cnt_q;
    abort_d  = 1'b0;
    serr     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          state_d  = S_START;
          start_d  = 1'b1;
          grant_d  = rdy1 ? 2'b10 : 2'b01;
          data_d   = rdy1 ? req1_data : req0_data;
          last_d   = rdy1 ? req1_last : req0_last;
          served_d = rdy1;
          cnt_d    = '0;
        end else if (state_q == S_HOLD) begin
          if (cnt_q == HOLD_LIM) begin
            abort_d = 1'b1;
            grant_d = 2'b00;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      S_START: begin
        state_d = S_WAIT_BUSY;
        cnt_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == START_LIM) begin
          // Transmitter never responded: drop the byte but keep the packet going.
          serr = 1'b1;
          done = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_WAIT_DONE: begin
        done = !tx_busy;
      end
      default: state_d = S_IDLE;
    endcase
    if (done) begin
      cnt_d = '0;
      if (last_q) begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end else begin
        state_d = S_HOLD;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      grant_q  <= 2'b00;
      last_q   <= 1'b0;
      served_q <= 1'b1;
      data_q   <= 8'h00;
      start_q  <= 1'b0;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      served_q <= served_d;
      data_q   <= data_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
      busy_q   <= busy_d;
    end
  end

  assign tx_start   = start_q;
  assign tx_data    = data_q;
  assign grant      = grant_q;
  assign sched_busy = busy_q;
  assign start_err  = serr;
  assign lock_abort = abort_q;

endmodule

// File: tb/tb_dsu_uart_txsched.sv
// Bench for dsu_uart_txsched: timestamp-based reference model checked every
// cycle, a simple transmitter model, directed scenarios and a random run.
module tb_dsu_uart_txsched;
  localparam int START_TO = 4;
  localparam int HOLD_TO  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
  logic       req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       tx_start, tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       sched_busy, start_err, lock_abort;

  always #5 clk = ~clk;

  dsu_uart_txsched #(.START_TO(START_TO), .HOLD_TO(HOLD_TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .sched_busy(sched_busy), .start_err(start_err), .lock_abort(lock_abort)
  );

  int checks = 0, errors = 0, cyc = 0;
  logic rst_next = 1'b0;

  // Requester byte queues: bit 8 is the last flag.
  logic [8:0] q0[$], q1[$];
  int pause0 = 0, pause1 = 0, pause_pct = 0;

  // Transmitter model.
  int blen = 10, busy_left = 0;
  bit busy_dead = 0, rand_blen = 0;

  // Reference model: who owns the transmitter, and timestamps of the byte in flight.
  int m_owner = -1, m_start = 0, m_hold = 0, m_abort = -1;
  bit m_pending = 0, m_seen = 0, m_last = 0, m_served = 1;
  logic [7:0] m_data = 8'h00;

  // Observation log for literal expectations.
  logic [7:0] sent[$];
  int n_starts, n_err, n_abort, t_start, t_first_start, t_err, t_abort, t_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_log();
    sent.delete();
    n_starts = 0; n_err = 0; n_abort = 0;
    t_start = -1; t_first_start = -1; t_err = -1; t_abort = -1; t_rdy = -1;
  endtask

  task automatic model_reset();
    m_owner = -1; m_pending = 0; m_seen = 0; m_last = 0; m_served = 1;
    m_abort = -1; m_data = 8'h00;
  endtask

  task automatic complete_byte();
    m_pending = 0;
    if (m_last) m_owner = -1;
    else m_hold = cyc + 1;
  endtask

  task automatic model_check_step();
    int pick;
    bit e_rdy0, e_rdy1, e_start, e_err, e_sbusy, e_abort;
    logic [1:0] e_grant;
    if (!rst) begin
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_grant", grant, 2'b00);
      check("rst_sched_busy", sched_busy, 0);
      check("rst_start_err", start_err, 0);
      check("rst_lock_abort", lock_abort, 0);
      model_reset();
    end else begin
      pick = -1;
      if (!m_pending) begin
        if (m_owner < 0) begin
          if (req0_valid && req1_valid) pick = m_served ? 0 : 1;
          else if (req0_valid) pick = 0;
          else if (req1_valid) pick = 1;
        end else if ((m_owner == 0 && req0_valid) || (m_owner == 1 && req1_valid)) begin
          pick = m_owner;
        end
      end
      e_rdy0  = (pick == 0);
      e_rdy1  = (pick == 1);
      e_start = m_pending && (cyc == m_start);
      e_err   = m_pending && !m_seen && (cyc == m_start + START_TO) && !tx_busy;
      e_grant = (m_owner < 0) ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10);
      e_sbusy = m_pending || (m_owner >= 0);
      e_abort = (cyc == m_abort);
      check("req0_ready", req0_ready, e_rdy0);
      check("req1_ready", req1_ready, e_rdy1);
      check("tx_start", tx_start, e_start);
      check("tx_data", tx_data, m_data);
      check("grant", grant, e_grant);
      check("sched_busy", sched_busy, e_sbusy);
      check("start_err", start_err, e_err);
      check("lock_abort", lock_abort, e_abort);

      if (pick >= 0) begin
        m_pending = 1; m_start = cyc + 1; m_seen = 0;
        m_owner = pick; m_served = (pick == 1);
        m_data = (pick == 1) ? req1_data : req0_data;
        m_last = (pick == 1) ? req1_last : req0_last;
        if (pick == 1) void'(q1.pop_front());
        else void'(q0.pop_front());
      end else if (m_pending) begin
        if (cyc > m_start) begin
          if (!m_seen) begin
            if (tx_busy) m_seen = 1;
            else if (cyc == m_start + START_TO) complete_byte();
          end else if (!tx_busy) begin
            complete_byte();
          end
        end
      end else if (m_owner >= 0) begin
        if (cyc - m_hold + 1 >= HOLD_TO) begin
          m_owner = -1;
          m_abort = cyc + 1;
        end
      end
    end

    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) t_rdy = cyc;
    if (tx_start) begin
      sent.push_back(tx_data);
      n_starts++;
      t_start = cyc;
      if (n_starts == 1) t_first_start = cyc;
      if (!busy_dead && rst) busy_left = rand_blen ? $urandom_range(6, 1) : blen;
    end
    if (start_err) begin n_err++; t_err = cyc; end
    if (lock_abort) begin n_abort++; t_abort = cyc; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rst = rst_next;
    if (!rst) begin
      busy_left = 0;
      tx_busy = 1'b0;
    end else begin
      tx_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
    if (pause0 > 0) pause0--;
    else if ($urandom_range(99) < pause_pct) pause0 = $urandom_range(12, 1);
    if (pause1 > 0) pause1--;
    else if ($urandom_range(99) < pause_pct) pause1 = $urandom_range(12, 1);
    req0_valid = (q0.size() > 0) && (pause0 == 0);
    req0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'($urandom);
    req0_last  = (q0.size() > 0) ? q0[0][8] : 1'($urandom);
    req1_valid = (q1.size() > 0) && (pause1 == 0);
    req1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'($urandom);
    req1_last  = (q1.size() > 0) ? q1[0][8] : 1'($urandom);
    @(negedge clk);
    cyc++;
    model_check_step();
  endtask

  task automatic do_reset();
    rst_next = 1'b0;
    repeat (3) tick();
    rst_next = 1'b1;
    tick();
    clear_log();
  endtask

  task automatic run_until_idle(input string name, input int budget);
    bit idle;
    idle = 0;
    for (int i = 0; i < budget && !idle; i++) begin
      tick();
      idle = !m_pending && (m_owner < 0) && (q0.size() == 0) && (q1.size() == 0) && (busy_left == 0);
    end
    check(name, idle, 1);
  endtask

  task automatic check_sent(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, sent.size(), exp.size());
    for (int i = 0; i < exp.size() && i < sent.size(); i++) check({name, "_byte"}, sent[i], exp[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_log();
    do_reset();

    // Single byte from port 0.
    q0.push_back(9'h155);
    run_until_idle("single_idle", 100);
    check("single_nstarts", n_starts, 1);
    check("single_latency", t_start - t_rdy, 1);
    check_sent("single", '{8'h55});

    // Tie between single-byte packets alternates starting with port 0.
    do_reset();
    q0.push_back(9'h1A0); q0.push_back(9'h1A0);
    q1.push_back(9'h1B0); q1.push_back(9'h1B0);
    run_until_idle("tie_idle", 200);
    check_sent("tie", '{8'hA0, 8'hB0, 8'hA0, 8'hB0});

    // Port 1 holds the lock for its whole packet while port 0 waits.
    do_reset();
    q1.push_back(9'h001); q1.push_back(9'h002); q1.push_back(9'h103);
    tick();
    q0.push_back(9'h1A0);
    run_until_idle("lock_idle", 200);
    check_sent("lock", '{8'h01, 8'h02, 8'h03, 8'hA0});

    // Owner abandons its packet; lock revoked after HOLD_TO idle cycles.
    do_reset();
    q1.push_back(9'h011);
    tick();
    q0.push_back(9'h1A0);
    run_until_idle("abort_idle", 200);
    check_sent("abort", '{8'h11, 8'hA0});
    check("abort_count", n_abort, 1);
    check("abort_delay", t_abort - t_first_start, 20);

    // Transmitter never raises busy.
    do_reset();
    busy_dead = 1;
    q0.push_back(9'h0C1); q0.push_back(9'h1C2);
    run_until_idle("timeout_idle", 100);
    check_sent("timeout", '{8'hC1, 8'hC2});
    check("timeout_count", n_err, 2);
    check("timeout_delay", t_err - t_start, START_TO);
    busy_dead = 0;

    // Reset while the transmitter is busy with a byte.
    do_reset();
    q0.push_back(9'h1D1);
    for (int i = 0; i < 40 && !(n_starts == 1 && tx_busy); i++) tick();
    check("midrst_busy_seen", tx_busy, 1);
    repeat (3) tick();
    rst_next = 1'b0;
    tick();
    check("midrst_grant", grant, 2'b00);
    tick();
    rst_next = 1'b1;
    tick();
    clear_log();
    q0.push_back(9'h1E1);
    run_until_idle("midrst_idle", 100);
    check_sent("midrst", '{8'hE1});

    // Random traffic with pauses and varying transmitter busy times.
    do_reset();
    rand_blen = 1;
    pause_pct = 12;
    for (int i = 0; i < 60; i++) begin
      q0.push_back({($urandom_range(2) == 0), 8'($urandom)});
      q1.push_back({($urandom_range(2) == 0), 8'($urandom)});
    end
    run_until_idle("random_idle", 8000);
    check("random_nstarts", n_starts, 120);
    pause_pct = 0;
    pause0 = 0;
    pause1 = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
